// File: rtl/lic_pkg.sv
// Shared definitions for the lic bus interface: FSM encoding, default
// register offsets within the timer region and the store-strobe width.
package lic_pkg;

  localparam int LIC_XLEN   = 64;
  localparam int LIC_STRB_W = LIC_XLEN / 8;

  localparam logic [15:0] LIC_MTIME_OFF    = 16'hBFF8;
  localparam logic [15:0] LIC_MTIMECMP_OFF = 16'h4000;

  typedef enum logic [0:0] {
    LIC_BIF_IDLE = 1'b0,
    LIC_BIF_RESP = 1'b1
  } lic_bif_state_e;

endpackage

// File: rtl/lic_bif_if.sv
// Valid/ready request and response channels between the core and lic_bif.
interface lic_bif_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 16
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic [XLEN/8-1:0]   req_wstrb;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [XLEN-1:0]     rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lic_bif_merge.sv
// Byte-strobe read-modify merge: bytes with a set strobe come from wdata,
// the rest keep the current register value.
module lic_bif_merge
  import lic_pkg::*;
#(
  parameter int XLEN = LIC_XLEN
) (
  input  logic [XLEN-1:0]   cur,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN/8-1:0] wstrb,
  output logic [XLEN-1:0]   merged
);
  logic [XLEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < XLEN/8; i++) begin
      mask[i*8 +: 8] = {8{wstrb[i]}};
    end
    merged = (cur & ~mask) | (wdata & mask);
  end
endmodule

// File: rtl/lic_bif.sv
// Bus slave in front of lic: decodes mtime/mtimecmp accesses into one-cycle
// write strobes and registered read data. LIC_BIF_ERR_EN enables error responses.
module lic_bif
  import lic_pkg::*;
#(
  parameter int                XLEN         = LIC_XLEN,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] MTIME_OFF    = ADDR_W'(LIC_MTIME_OFF),
  parameter logic [ADDR_W-1:0] MTIMECMP_OFF = ADDR_W'(LIC_MTIMECMP_OFF)
) (
  input  logic            clk,
  input  logic            reset,
  lic_bif_if.slave        bif,
  input  logic [XLEN-1:0] lic_mtime_read,
  output logic [XLEN-1:0] lic_mtime_write,
  output logic            lic_mtime_write_ena,
  input  logic [XLEN-1:0] lic_mtimecmp_read,
  output logic [XLEN-1:0] lic_mtimecmp_write,
  output logic            lic_mtimecmp_write_ena
);
  lic_bif_state_e state, state_nxt;

  logic            accept;
  logic            hit_mtime, hit_mtimecmp, aligned, hit_ok, any_strb;
  logic [XLEN-1:0] sel_read, merged_mtime, merged_mtimecmp;

  logic            wena_mtime_p1, wena_mtimecmp_p1;
  logic [XLEN-1:0] wdata_mtime_p1, wdata_mtimecmp_p1, rdata_p1;

  always_comb begin
    state_nxt     = state;
    bif.req_ready = 1'b0;
    bif.rsp_valid = 1'b0;
    case (state)
      LIC_BIF_IDLE: begin
        bif.req_ready = 1'b1;
        if (bif.req_valid) state_nxt = LIC_BIF_RESP;
      end
      LIC_BIF_RESP: begin
        bif.rsp_valid = 1'b1;
        if (bif.rsp_ready) state_nxt = LIC_BIF_IDLE;
      end
      default: state_nxt = LIC_BIF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= LIC_BIF_IDLE;
    else       state <= state_nxt;
  end

  // Stage 0: decode and merge against the lic value seen in the accept cycle
  assign accept       = bif.req_valid & bif.req_ready;
  assign hit_mtime    = (bif.req_addr[ADDR_W-1:3] == MTIME_OFF[ADDR_W-1:3]);
  assign hit_mtimecmp = (bif.req_addr[ADDR_W-1:3] == MTIMECMP_OFF[ADDR_W-1:3]);
  assign aligned      = (bif.req_addr[2:0] == 3'b000);
  assign hit_ok       = (hit_mtime | hit_mtimecmp) & aligned;
  assign any_strb     = |bif.req_wstrb;
  assign sel_read     = hit_mtime ? lic_mtime_read : lic_mtimecmp_read;

  lic_bif_merge #(.XLEN(XLEN)) u_merge_mtime (
    .cur    (lic_mtime_read),
    .wdata  (bif.req_wdata),
    .wstrb  (bif.req_wstrb),
    .merged (merged_mtime)
  );

  lic_bif_merge #(.XLEN(XLEN)) u_merge_mtimecmp (
    .cur    (lic_mtimecmp_read),
    .wdata  (bif.req_wdata),
    .wstrb  (bif.req_wstrb),
    .merged (merged_mtimecmp)
  );

  // Stage 1: registered response data and single-cycle write strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      wena_mtime_p1     <= 1'b0;
      wena_mtimecmp_p1  <= 1'b0;
      wdata_mtime_p1    <= '0;
      wdata_mtimecmp_p1 <= '0;
      rdata_p1          <= '0;
    end else begin
      wena_mtime_p1    <= 1'b0;
      wena_mtimecmp_p1 <= 1'b0;
      if (accept) begin
        rdata_p1         <= (!bif.req_write && hit_ok) ? sel_read : '0;
        wena_mtime_p1    <= bif.req_write & hit_ok & any_strb & hit_mtime;
        wena_mtimecmp_p1 <= bif.req_write & hit_ok & any_strb & ~hit_mtime;
        if (bif.req_write && hit_ok && any_strb && hit_mtime)
          wdata_mtime_p1 <= merged_mtime;
        if (bif.req_write && hit_ok && any_strb && !hit_mtime)
          wdata_mtimecmp_p1 <= merged_mtimecmp;
      end
    end
  end

`ifdef LIC_BIF_ERR_EN
  logic err_p1;

  always_ff @(posedge clk) begin
    if (reset)       err_p1 <= 1'b0;
    else if (accept) err_p1 <= ~hit_ok;
  end

  assign bif.rsp_err = err_p1;
`else
  assign bif.rsp_err = 1'b0;
`endif

  assign bif.rsp_rdata = rdata_p1;

  // A reset sampled in the pulse cycle must not let lic load the value
  assign lic_mtime_write_ena    = wena_mtime_p1 & ~reset;
  assign lic_mtimecmp_write_ena = wena_mtimecmp_p1 & ~reset;
  assign lic_mtime_write        = wdata_mtime_p1;
  assign lic_mtimecmp_write     = wdata_mtimecmp_p1;
endmodule

// File: tb/tb_lic_bif.sv
// Scoreboard bench for lic_bif with a small lic timer model; expected
// responses and write strobes are queued at issue and checked by a monitor.
module tb_lic_bif;
  import lic_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lic_bif_if #(.XLEN(64), .ADDR_W(16)) bif ();

  logic [63:0] mtime = '0;
  logic [63:0] mtimecmp = '0;
  logic [63:0] mtime_wr, cmp_wr;
  logic        mtime_we, cmp_we;

  lic_bif dut (
    .clk                    (clk),
    .reset                  (reset),
    .bif                    (bif),
    .lic_mtime_read         (mtime),
    .lic_mtime_write        (mtime_wr),
    .lic_mtime_write_ena    (mtime_we),
    .lic_mtimecmp_read      (mtimecmp),
    .lic_mtimecmp_write     (cmp_wr),
    .lic_mtimecmp_write_ena (cmp_we)
  );

`ifdef LIC_BIF_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {logic [63:0] rdata; logic err;} rsp_t;
  typedef struct {logic is_cmp; logic [63:0] data;} wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  // lic timer model: write strobe wins, then bench override, then increment
  logic        inc_en = 1'b0;
  logic        frc_mtime = 1'b0, frc_cmp = 1'b0;
  logic [63:0] frc_mtime_val = '0, frc_cmp_val = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mtime_we)       mtime <= mtime_wr;
    else if (frc_mtime) mtime <= frc_mtime_val;
    else if (inc_en)    mtime <= mtime + 64'd1;
    if (cmp_we)         mtimecmp <= cmp_wr;
    else if (frc_cmp)   mtimecmp <= frc_cmp_val;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mtime_we || cmp_we) begin
      chk("single_wena", {63'b0, mtime_we & cmp_we}, 64'd0);
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {62'b0, cmp_we, mtime_we}, 64'd0);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_target", {63'b0, cmp_we}, {63'b0, w.is_cmp});
        chk("wr_data", cmp_we ? cmp_wr : mtime_wr, w.data);
      end
    end
    if (!reset && bif.rsp_valid && bif.rsp_ready) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", bif.rsp_rdata, 64'hDEAD);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp_rdata", bif.rsp_rdata, r.rdata);
        chk("rsp_err", {63'b0, bif.rsp_err}, {63'b0, r.err});
      end
    end
  end

  task automatic set_lic(input logic [63:0] mt, input logic [63:0] cmp, input logic inc);
    @(negedge clk);
    frc_mtime = 1'b1; frc_mtime_val = mt;
    frc_cmp   = 1'b1; frc_cmp_val   = cmp;
    inc_en    = 1'b0;
    @(negedge clk);
    frc_mtime = 1'b0; frc_cmp = 1'b0; inc_en = inc;
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wstrb);
    int t;
    t = 0;
    @(negedge clk);
    while (!bif.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bif.req_ready) chk("req_ready_timeout", {63'b0, bif.req_ready}, 64'd1);
    bif.req_valid = 1'b1;
    bif.req_write = wr;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    bif.req_wstrb = wstrb;
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!bif.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bif.req_ready) chk("idle_timeout", {63'b0, bif.req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t0_mtime;
    int          t0_cyc;

    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.req_wstrb = '0;
    bif.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'b0, bif.req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'b0, bif.rsp_valid}, 64'd0);
    chk("rst_rdata", bif.rsp_rdata, 64'd0);
    chk("rst_err", {63'b0, bif.rsp_err}, 64'd0);
    chk("rst_mtime_we", {63'b0, mtime_we}, 64'd0);
    chk("rst_cmp_we", {63'b0, cmp_we}, 64'd0);
    chk("rst_mtime_wr", mtime_wr, 64'd0);
    chk("rst_cmp_wr", cmp_wr, 64'd0);
    reset = 1'b0;

    // Full store to mtimecmp: one pulse in N+1, lic loads it
    set_lic(64'd0, 64'd0, 1'b1);
    rsp_q.push_back('{64'd0, 1'b0});
    wr_q.push_back('{1'b1, 64'h0000_0000_0000_1000});
    issue(1'b1, 16'h4000, 64'h0000_0000_0000_1000, 8'hFF);
    @(negedge clk);
    chk("t1_cmp_we_n1", {63'b0, cmp_we}, 64'd1);
    chk("t1_rsp_valid_n1", {63'b0, bif.rsp_valid}, 64'd1);
    chk("t1_req_ready_n1", {63'b0, bif.req_ready}, 64'd0);
    @(negedge clk);
    chk("t1_cmp_we_n2", {63'b0, cmp_we}, 64'd0);
    chk("t1_req_ready_n2", {63'b0, bif.req_ready}, 64'd1);
    chk("t1_mtimecmp", mtimecmp, 64'h0000_0000_0000_1000);

    // Load mtime under 5 cycles of backpressure while lic moves on
    set_lic(64'h55, 64'h1000, 1'b0);
    bif.rsp_ready = 1'b0;
    rsp_q.push_back('{64'h55, 1'b0});
    issue(1'b0, 16'hBFF8, 64'd0, 8'h00);
    frc_mtime = 1'b1; frc_mtime_val = 64'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_rsp_valid", {63'b0, bif.rsp_valid}, 64'd1);
      chk("t2_rdata_hold", bif.rsp_rdata, 64'h55);
      chk("t2_req_ready", {63'b0, bif.req_ready}, 64'd0);
    end
    frc_mtime = 1'b0;
    chk("t2_mtime_moved", mtime, 64'h99);
    @(posedge clk);
    #1 bif.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_req_ready_hs", {63'b0, bif.req_ready}, 64'd0);
    @(negedge clk);
    chk("t2_req_ready_after", {63'b0, bif.req_ready}, 64'd1);
    chk("t2_rsp_valid_after", {63'b0, bif.rsp_valid}, 64'd0);

    // Partial store merges into current mtimecmp, then read it back
    set_lic(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    rsp_q.push_back('{64'd0, 1'b0});
    wr_q.push_back('{1'b1, 64'hFFFF_FFFF_1234_5678});
    issue(1'b1, 16'h4000, 64'hAAAA_AAAA_1234_5678, 8'h0F);
    wait_idle();
    chk("t3_mtimecmp", mtimecmp, 64'hFFFF_FFFF_1234_5678);
    rsp_q.push_back('{64'hFFFF_FFFF_1234_5678, 1'b0});
    issue(1'b0, 16'h4000, 64'd0, 8'h00);
    wait_idle();

    // Unmapped and misaligned accesses: no writes, RAZ, err per build
    set_lic(64'h1234, 64'h5678, 1'b0);
    rsp_q.push_back('{64'd0, EXP_ERR});
    issue(1'b0, 16'h0100, 64'd0, 8'h00);
    @(negedge clk);
    chk("t4_no_we_unmapped", {62'b0, cmp_we, mtime_we}, 64'd0);
    wait_idle();
    rsp_q.push_back('{64'd0, EXP_ERR});
    issue(1'b0, 16'h4004, 64'd0, 8'h00);
    @(negedge clk);
    chk("t4_no_we_misaligned", {62'b0, cmp_we, mtime_we}, 64'd0);
    wait_idle();
    rsp_q.push_back('{64'd0, EXP_ERR});
    issue(1'b1, 16'hBFFC, 64'hFFFF, 8'hFF);
    wait_idle();
    rsp_q.push_back('{64'd0, EXP_ERR});
    issue(1'b1, 16'h0100, 64'hFFFF, 8'hFF);
    wait_idle();
    chk("t4_mtime_kept", mtime, 64'h1234);
    chk("t4_cmp_kept", mtimecmp, 64'h5678);

    // Reset in the pulse cycle suppresses the write and drops the response
    set_lic(64'h100, 64'h5678, 1'b0);
    bif.rsp_ready = 1'b0;
    issue(1'b1, 16'hBFF8, 64'h77, 8'hFF);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_we_suppressed", {63'b0, mtime_we}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", {63'b0, bif.rsp_valid}, 64'd0);
    chk("t5_req_ready", {63'b0, bif.req_ready}, 64'd1);
    chk("t5_mtime_kept", mtime, 64'h100);
    bif.rsp_ready = 1'b1;

    // Zero-strobe store to mtime: response only, timer keeps counting
    set_lic(64'h200, 64'h5678, 1'b1);
    t0_mtime = mtime;
    t0_cyc   = cyc;
    rsp_q.push_back('{64'd0, 1'b0});
    issue(1'b1, 16'hBFF8, 64'hFFFF_FFFF, 8'h00);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("t6_mtime_counting", mtime - t0_mtime, 64'(cyc - t0_cyc));
    inc_en = 1'b0;

    repeat (3) @(negedge clk);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lic_bif.md
Name: lic_bif

Overview:
- Memory-mapped bus slave directly upstream of the local interrupt controller (lic).
- Decodes core load/store requests to the timer region and converts them into lic's mtime/mtimecmp write-enable/write-data strobes.
- Returns read data from lic's mtime/mtimecmp read ports.
- Valid/ready request and response channels; one outstanding transaction.

Parameters:
- XLEN, 64: data width; must equal CPU6_XLEN.
- ADDR_W, 16: request address width (byte address within the timer region).
- MTIME_OFF, 16'hBFF8: byte offset of mtime; must be 8-byte aligned.
- MTIMECMP_OFF, 16'h4000: byte offset of mtimecmp; must be 8-byte aligned.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- bif_req_valid  in  1  request valid
- bif_req_ready  out  1  request accepted when valid&ready
- bif_req_write  in  1  1=store, 0=load
- bif_req_addr  in  ADDR_W  byte address
- bif_req_wdata  in  XLEN  store data
- bif_req_wstrb  in  XLEN/8  byte enables for stores
- bif_rsp_valid  out  1  response valid
- bif_rsp_ready  in  1  response consumed when valid&ready
- bif_rsp_rdata  out  XLEN  load data (0 for stores)
- bif_rsp_err  out  1  access error
- lic_mtime_read  in  XLEN  current mtime from lic
- lic_mtime_write  out  XLEN  new mtime
- lic_mtime_write_ena  out  1  one-cycle mtime write pulse
- lic_mtimecmp_read  in  XLEN  current mtimecmp from lic
- lic_mtimecmp_write  out  XLEN  new mtimecmp
- lic_mtimecmp_write_ena  out  1  one-cycle mtimecmp write pulse

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, bif_req_ready=1.
  - bif_rsp_valid=0, bif_rsp_rdata=0, bif_rsp_err=0.
  - Both write_ena=0, both write data=0.
- FSM states: IDLE, RESP.
  - IDLE: bif_req_ready=1. Accept in cycle N moves to RESP at N+1.
  - RESP: bif_req_ready=0, bif_rsp_valid=1.
  - Response fields are held stable until bif_rsp_ready=1, then IDLE in the next cycle.
  - Minimum 2 cycles per transaction; no back-to-back accepts.
- Decode (in cycle N):
  - hit_mtime = (addr[ADDR_W-1:3]==MTIME_OFF[ADDR_W-1:3]); hit_mtimecmp likewise.
  - addr[2:0] must be 0; otherwise the access is misaligned.
- Load: rdata is the selected lic read value sampled in cycle N, registered and presented from N+1.
- Store merge: new = (cur_read & ~mask) | (wdata & mask).
  - mask expands each wstrb bit to 8 bits.
  - cur_read is the selected lic read value in cycle N.
  - The merged value is registered. The matching write_ena pulses high for exactly cycle N+1, then lic loads it at the end of N+1.
  - The mtime increment between N and N+1 is overwritten (accepted one-tick loss).
  - wstrb=0: no write_ena pulse; response is still returned, err=0.
- At most one write_ena is high in any cycle; write_ena is never high while in IDLE without a preceding accept.
- Unmapped or misaligned access: no write pulse, rdata=0; err per Optional Feature.
- Reset mid-operation:
  - A pending RESP is dropped; rsp_valid falls in the cycle after reset is sampled.
  - A scheduled write_ena pulse in the same cycle is suppressed.
- Backpressure: rsp_ready held low for any number of cycles leaves rdata/err unchanged. lic values keep changing meanwhile; the registered rdata does not.

Optional Feature:
- Macro: LIC_BIF_ERR_EN.
- Defined: unmapped or misaligned access returns bif_rsp_err=1, rdata=0, no write.
- Undefined: such accesses complete with err=0, rdata=0, no write (silent RAZ/WI); bif_rsp_err tied to 0.

Decomposition:
- Shared package lic_pkg:
  - state encoding LIC_BIF_IDLE/LIC_BIF_RESP;
  - default offsets LIC_MTIME_OFF, LIC_MTIMECMP_OFF;
  - strobe width constant XLEN/8.
- One sub-module, lic_bif_merge: combinational strobe-to-mask expansion and read-modify merge. It is reused for both registers.

Test Plan:
- Store mtimecmp=64'h0000_0000_0000_1000, wstrb=8'hFF, at MTIMECMP_OFF -> lic_mtimecmp_write_ena high for exactly one cycle (N+1), lic_mtimecmp_write=64'h1000, rsp err=0.
- Load mtime with lic_mtime_read=64'h55 at cycle N, rsp_ready held low 5 cycles -> rsp_valid stays high, rdata stays 64'h55 throughout, req_ready=0 until one cycle after the handshake.
- Partial store wstrb=8'h0F, wdata=64'hAAAA_AAAA_1234_5678, mtimecmp current 64'hFFFF_FFFF_FFFF_FFFF -> lic_mtimecmp_write=64'hFFFF_FFFF_1234_5678.
- Load at unmapped offset 16'h0100 and misaligned 16'h4004 -> no write_ena; rdata=0. err=1 with LIC_BIF_ERR_EN, err=0 without.
- Store to mtime accepted, reset asserted in cycle N+1 -> lic_mtime_write_ena=0 that cycle, rsp_valid=0, req_ready=1 after reset.
- Store with wstrb=8'h00 to mtime -> no write pulse, response err=0; lic mtime continues incrementing.
